// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared definitions for the parametrised UART receiver:
//             one-hot state encodings, counter-width helpers and the
//             parameter legality check used at elaboration.
//  Config   : UART_RX_PARITY_EN adds the PARITY state to the state type.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_ST_W = 6;

    // One-hot encodings; PARITY keeps its code even when the state is
    // compiled out so the other encodings stay stable between builds.
    localparam logic [c_ST_W-1:0] c_ST_IDLE   = 6'b000001;
    localparam logic [c_ST_W-1:0] c_ST_START  = 6'b000010;
    localparam logic [c_ST_W-1:0] c_ST_DATA   = 6'b000100;
    localparam logic [c_ST_W-1:0] c_ST_PARITY = 6'b001000;
    localparam logic [c_ST_W-1:0] c_ST_STOP   = 6'b010000;
    localparam logic [c_ST_W-1:0] c_ST_BREAK  = 6'b100000;

    typedef enum logic [c_ST_W-1:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_START  = c_ST_START,
        ST_DATA   = c_ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = c_ST_PARITY,
`endif
        ST_STOP   = c_ST_STOP,
        ST_BREAK  = c_ST_BREAK
    } uart_rx_state_t;

    // Width of a counter that must hold 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_ok(input int data_bits, input int stop_bits,
                                     input int oversample);
        return (data_bits >= 5) && (data_bits <= 9) &&
               ((stop_bits == 1) || (stop_bits == 2)) &&
               (oversample >= 8) && ((oversample % 2) == 0);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sync
//  Purpose  : Two-flop synchroniser for the asynchronous serial line.
//             Resets to 1 so the receiver sees an idle line out of reset.
//  Ports    : i_clock  - system clock
//             i_reset  - synchronous, active-high reset
//             i_rx     - asynchronous serial input
//             o_rx_s   - synchronised serial line
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_rx,
    output logic o_rx_s
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
        end
    end

    assign o_rx_s = r_sync;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_param
//  Purpose  : Parametrised oversampling UART receiver. Start, data, optional
//             parity and stop bits are sampled mid-bit using an external
//             oversample tick. A complete good frame produces a one-cycle
//             o_valid with the word on o_data; bad frames produce a one-cycle
//             error pulse instead.
//  Params   : DATA_BITS (5..9), STOP_BITS (1/2), OVERSAMPLE (even, >=8)
//  Ports    : i_clock, i_reset (sync, active-high), i_tick (oversample
//             enable), i_rx (async line, idle high), i_parity_odd,
//             o_data, o_valid, o_frame_err, o_parity_err, o_busy
//  Config   : define UART_RX_PARITY_EN to expect one parity bit after the
//             data bits; otherwise o_parity_err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_rx,
    input  logic                 i_parity_odd,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_busy
);

    localparam int c_CNT_W = cnt_width(OVERSAMPLE);
    localparam int c_IDX_W = cnt_width(DATA_BITS);

    localparam logic [c_CNT_W-1:0] c_CNT_HALF  = c_CNT_W'(OVERSAMPLE/2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL  = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_BIT  = c_IDX_W'(DATA_BITS - 1);
    localparam logic               c_LAST_STOP = 1'(STOP_BITS - 1);

    if (!params_ok(DATA_BITS, STOP_BITS, OVERSAMPLE)) begin : g_param_check
        $error("uart_rx_param: illegal DATA_BITS/STOP_BITS/OVERSAMPLE");
    end

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic w_rx_s;

    uart_rx_sync u_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_rx    (i_rx),
        .o_rx_s  (w_rx_s)
    );

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    uart_rx_state_t         r_state,     w_state;
    logic [c_CNT_W-1:0]     r_tick_cnt,  w_tick_cnt;
    logic [c_IDX_W-1:0]     r_bit_idx,   w_bit_idx;
    logic                   r_stop_idx,  w_stop_idx;
    logic [DATA_BITS-1:0]   r_shift,     w_shift;
    logic [DATA_BITS-1:0]   r_data,      w_data;
    logic                   r_valid,     w_valid;
    logic                   r_frame_err, w_frame_err;
    logic                   r_par_err,   w_par_err;
    logic                   r_parity_err, w_parity_err;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_tick_cnt   <= '0;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_shift      <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_par_err    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_tick_cnt   <= w_tick_cnt;
            r_bit_idx    <= w_bit_idx;
            r_stop_idx   <= w_stop_idx;
            r_shift      <= w_shift;
            r_data       <= w_data;
            r_valid      <= w_valid;
            r_frame_err  <= w_frame_err;
            r_par_err    <= w_par_err;
            r_parity_err <= w_parity_err;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Bit-period counters only move on i_tick; IDLE and
    // BREAK react to the line level directly.
    // ------------------------------------------------------------------
    logic w_cnt_full;
    assign w_cnt_full = (r_tick_cnt == c_CNT_FULL);

    always_comb begin
        w_state      = r_state;
        w_tick_cnt   = r_tick_cnt;
        w_bit_idx    = r_bit_idx;
        w_stop_idx   = r_stop_idx;
        w_shift      = r_shift;
        w_data       = r_data;
        w_valid      = 1'b0;
        w_frame_err  = 1'b0;
        w_par_err    = r_par_err;
        w_parity_err = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_par_err = 1'b0;
                if (!w_rx_s) begin
                    w_state    = ST_START;
                    w_tick_cnt = '0;
                end
            end

            ST_START: begin
                if (i_tick) begin
                    if (r_tick_cnt == c_CNT_HALF) begin
                        // Mid start bit: still low means a real start,
                        // otherwise it was a glitch.
                        w_tick_cnt = '0;
                        if (!w_rx_s) begin
                            w_state   = ST_DATA;
                            w_bit_idx = '0;
                        end else begin
                            w_state = ST_IDLE;
                        end
                    end else begin
                        w_tick_cnt = r_tick_cnt + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (i_tick) begin
                    if (w_cnt_full) begin
                        w_tick_cnt         = '0;
                        w_shift[r_bit_idx] = w_rx_s;
                        if (r_bit_idx == c_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            w_state = ST_PARITY;
`else
                            w_state    = ST_STOP;
                            w_stop_idx = 1'b0;
`endif
                        end else begin
                            w_bit_idx = r_bit_idx + 1'b1;
                        end
                    end else begin
                        w_tick_cnt = r_tick_cnt + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (i_tick) begin
                    if (w_cnt_full) begin
                        // XOR over data plus parity bit is 1 for an odd
                        // number of ones; that must match the selected mode.
                        w_tick_cnt = '0;
                        w_par_err  = ((^{r_shift, w_rx_s}) != i_parity_odd);
                        w_state    = ST_STOP;
                        w_stop_idx = 1'b0;
                    end else begin
                        w_tick_cnt = r_tick_cnt + 1'b1;
                    end
                end
            end
`endif

            ST_STOP: begin
                if (i_tick) begin
                    if (w_cnt_full) begin
                        w_tick_cnt = '0;
                        if (!w_rx_s) begin
                            // Framing error wins over any pending parity error.
                            w_frame_err = 1'b1;
                            w_state     = ST_BREAK;
                        end else if (r_stop_idx == c_LAST_STOP) begin
                            w_state = ST_IDLE;
                            if (r_par_err) begin
                                w_parity_err = 1'b1;
                            end else begin
                                w_valid = 1'b1;
                                w_data  = r_shift;
                            end
                        end else begin
                            w_stop_idx = 1'b1;
                        end
                    end else begin
                        w_tick_cnt = r_tick_cnt + 1'b1;
                    end
                end
            end

            ST_BREAK: begin
                // Hold here until the line returns high so a stuck-low line
                // does not look like an endless stream of start bits.
                if (w_rx_s) begin
                    w_state = ST_IDLE;
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
    assign o_parity_err = r_parity_err;
`else
    // No parity bit in the frame: the parity path is inert.
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = i_parity_odd;
    assign o_parity_err        = 1'b0;
`endif

endmodule : uart_rx_param
`default_nettype wire
